// File: rtl/vga_tile_pkg.sv
// Shared VGA tile-map timing constants, fetch FSM state type and map address sizing helper.
package vga_tile_pkg;

  localparam int unsigned VGA_H_LEFT    = 144;
  localparam int unsigned VGA_V_TOP     = 31;
  localparam int unsigned VGA_H_ACTIVE  = 640;
  localparam int unsigned VGA_H_TOTAL   = 800;
  localparam int unsigned VGA_V_TOTAL   = 525;
  localparam int unsigned VGA_TILE_LOG2 = 3;
  localparam int unsigned VGA_COLS      = VGA_H_ACTIVE >> VGA_TILE_LOG2;
  localparam int unsigned VGA_ROWS      = 60;
  localparam int unsigned VGA_IDX_W     = 4;

  function automatic int unsigned map_aw_f(input int unsigned cols, input int unsigned rows);
    return $clog2(cols * rows);
  endfunction

  localparam int unsigned VGA_MAP_AW = map_aw_f(VGA_COLS, VGA_ROWS);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/tile_line_buffer.sv
// Ping-pong tile index line buffer: synchronous write into the back bank,
// asynchronous read from the front bank, swap flips the roles.
module tile_line_buffer #(
  parameter int unsigned COLS  = 80,
  parameter int unsigned IDX_W = 4,
  parameter int unsigned COL_W = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [COL_W-1:0] wr_addr,
  input  logic [IDX_W-1:0] wr_data,
  input  logic             swap,
  input  logic [COL_W-1:0] rd_addr,
  output logic [IDX_W-1:0] rd_data
);

  logic [IDX_W-1:0] bank0_q [COLS];
  logic [IDX_W-1:0] bank1_q [COLS];
  logic             sel_q;
  logic             sel_d;

  // Banks carry no reset so they can map onto distributed RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (sel_q) bank0_q[wr_addr] <= wr_data;
      else       bank1_q[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    sel_d = sel_q ^ swap;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sel_q <= 1'b0;
    else        sel_q <= sel_d;
  end

  assign rd_data = sel_q ? bank1_q[rd_addr] : bank0_q[rd_addr];

endmodule

// File: rtl/tile_row_prefetcher.sv
// Tile-map front end: refills a ping-pong row buffer from the screen map during
// horizontal blanking and maps each active pixel to its tile index.
module tile_row_prefetcher
  import vga_tile_pkg::*;
#(
  parameter int unsigned H_LEFT    = VGA_H_LEFT,
  parameter int unsigned V_TOP     = VGA_V_TOP,
  parameter int unsigned H_ACTIVE  = VGA_H_ACTIVE,
  parameter int unsigned TILE_LOG2 = VGA_TILE_LOG2,
  parameter int unsigned COLS      = VGA_COLS,
  parameter int unsigned ROWS      = VGA_ROWS,
  parameter int unsigned IDX_W     = VGA_IDX_W,
  parameter int unsigned MAP_AW    = VGA_MAP_AW
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [9:0]           hcount,
  input  logic [9:0]           vcount,
  input  logic                 bright,
  output logic                 map_rd,
  output logic [MAP_AW-1:0]    map_addr,
  input  logic [IDX_W-1:0]     map_data,
  output logic [IDX_W-1:0]     tselect,
  output logic                 tselect_valid,
  output logic [TILE_LOG2-1:0] px,
  output logic [TILE_LOG2-1:0] py,
  output logic                 underrun,
  input  logic                 err_clr
);

  localparam int unsigned COL_W  = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [9:0]  TRIG_H = 10'(H_LEFT + H_ACTIVE + 1);

  fetch_state_e         state_q, state_d;
  logic [COL_W-1:0]     col_q, col_d;
  logic                 map_rd_q, map_rd_d;
  logic [MAP_AW-1:0]    map_addr_q, map_addr_d;
  logic                 row_valid_q, row_valid_d;
  logic                 underrun_q, underrun_d;
  logic [IDX_W-1:0]     tselect_q, tselect_d;
  logic                 tselect_valid_q, tselect_valid_d;
  logic [TILE_LOG2-1:0] px_q, px_d;
  logic [TILE_LOG2-1:0] py_q, py_d;

  logic [9:0]           vdiff_c;
  logic [9:0]           row_c;
  logic                 trigger_c;
  logic                 wr_en_c;
  logic [COL_W-1:0]     wr_addr_c;
  logic                 swap_c;
  logic [9:0]           x_c;
  logic [9:0]           tcol_c;
  logic [COL_W-1:0]     rd_addr_c;
  logic [IDX_W-1:0]     rd_data_c;

  // Row r is fetched on the blanking of the line just before its first line.
  always_comb begin
    vdiff_c   = vcount - 10'(V_TOP);
    row_c     = vdiff_c >> TILE_LOG2;
    trigger_c = (hcount == TRIG_H) && (vdiff_c[TILE_LOG2-1:0] == '0) && (row_c < 10'(ROWS));
  end

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    map_rd_d    = map_rd_q;
    map_addr_d  = map_addr_q;
    row_valid_d = row_valid_q;
    wr_en_c     = 1'b0;
    wr_addr_c   = col_q - COL_W'(1);
    swap_c      = 1'b0;
    underrun_d  = underrun_q;

    case (state_q)
      ST_IDLE: begin
        if (trigger_c) begin
          state_d    = ST_FETCH;
          col_d      = '0;
          map_rd_d   = 1'b1;
          map_addr_d = MAP_AW'(row_c) * MAP_AW'(COLS);
        end
      end
      ST_FETCH: begin
        // Data for the previous issue lands this cycle.
        wr_en_c = (col_q != '0);
        if (col_q == COL_W'(COLS - 1)) begin
          state_d  = ST_DRAIN;
          map_rd_d = 1'b0;
        end else begin
          col_d      = col_q + COL_W'(1);
          map_addr_d = map_addr_q + MAP_AW'(1);
        end
      end
      ST_DRAIN: begin
        wr_en_c     = 1'b1;
        wr_addr_c   = col_q;
        swap_c      = 1'b1;
        row_valid_d = 1'b1;
        state_d     = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A set condition beats a simultaneous clear.
    if ((state_q != ST_IDLE) && (bright || trigger_c)) underrun_d = 1'b1;
    else if (err_clr)                                  underrun_d = 1'b0;
  end

  always_comb begin
    x_c             = hcount - 10'(H_LEFT) - 10'd1;
    tcol_c          = x_c >> TILE_LOG2;
    rd_addr_c       = (tcol_c < 10'(COLS)) ? COL_W'(tcol_c) : '0;
    tselect_d       = '0;
    tselect_valid_d = 1'b0;
    px_d            = '0;
    py_d            = '0;
    if (bright) begin
      tselect_valid_d = 1'b1;
      tselect_d       = row_valid_q ? rd_data_c : '0;
      px_d            = TILE_LOG2'(x_c);
      py_d            = TILE_LOG2'(vcount - 10'(V_TOP) - 10'd1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      col_q           <= '0;
      map_rd_q        <= 1'b0;
      map_addr_q      <= '0;
      row_valid_q     <= 1'b0;
      underrun_q      <= 1'b0;
      tselect_q       <= '0;
      tselect_valid_q <= 1'b0;
      px_q            <= '0;
      py_q            <= '0;
    end else begin
      state_q         <= state_d;
      col_q           <= col_d;
      map_rd_q        <= map_rd_d;
      map_addr_q      <= map_addr_d;
      row_valid_q     <= row_valid_d;
      underrun_q      <= underrun_d;
      tselect_q       <= tselect_d;
      tselect_valid_q <= tselect_valid_d;
      px_q            <= px_d;
      py_q            <= py_d;
    end
  end

  tile_line_buffer #(
    .COLS  (COLS),
    .IDX_W (IDX_W),
    .COL_W (COL_W)
  ) u_line_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en_c),
    .wr_addr (wr_addr_c),
    .wr_data (map_data),
    .swap    (swap_c),
    .rd_addr (rd_addr_c),
    .rd_data (rd_data_c)
  );

  assign map_rd        = map_rd_q;
  assign map_addr      = map_addr_q;
  assign tselect       = tselect_q;
  assign tselect_valid = tselect_valid_q;
  assign px            = px_q;
  assign py            = py_q;
  assign underrun      = underrun_q;

endmodule

// File: tb/tb_tile_row_prefetcher.sv
// Scoreboard bench for tile_row_prefetcher: raster-style stimulus, a row-level
// reference model, and a monitor comparing display/underrun/map fetch streams.
module tb_tile_row_prefetcher;

  localparam int NCOLS = 80;
  localparam int NROWS = 60;
  localparam int NMAP  = NCOLS * NROWS;

  typedef struct packed {
    logic       und;
    logic       val;
    logic [3:0] tsel;
    logic [2:0] px;
    logic [2:0] py;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  hcount, vcount;
  logic        bright, err_clr;
  logic        map_rd;
  logic [12:0] map_addr;
  logic [3:0]  map_data;
  logic [3:0]  tselect;
  logic        tselect_valid;
  logic [2:0]  px, py;
  logic        underrun;

  tile_row_prefetcher dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .hcount        (hcount),
    .vcount        (vcount),
    .bright        (bright),
    .map_rd        (map_rd),
    .map_addr      (map_addr),
    .map_data      (map_data),
    .tselect       (tselect),
    .tselect_valid (tselect_valid),
    .px            (px),
    .py            (py),
    .underrun      (underrun),
    .err_clr       (err_clr)
  );

  always #5 clk = ~clk;

  logic [3:0] map_mem [NMAP];

  // Screen map memory: one-cycle read latency, junk when not read.
  always @(posedge clk) begin
    if (map_rd && map_addr < 13'(NMAP)) map_data <= map_mem[map_addr];
    else                                map_data <= 4'($urandom);
  end

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  int   addr_q[$];

  // Reference model state
  int         cyc = 0;
  bit         pend = 0;
  int         trig_cyc = 0;
  int         swap_cyc = 0;
  bit         front_rv = 0;
  bit         und_m = 0;
  logic [3:0] front_row [NCOLS];
  logic [3:0] pend_row  [NCOLS];

  exp_t mon_e;
  exp_t mon_a;
  int   mon_addr;

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_a = '{und: underrun, val: tselect_valid, tsel: tselect, px: px, py: py};
      checks++;
      if (mon_a.und !== mon_e.und) begin
        errors++;
        $display("FAIL underrun t=%0t got=%0b want=%0b", $time, mon_a.und, mon_e.und);
      end
      checks++;
      if ({mon_a.val, mon_a.tsel, mon_a.px, mon_a.py} !== {mon_e.val, mon_e.tsel, mon_e.px, mon_e.py}) begin
        errors++;
        $display("FAIL display t=%0t h=%0d v=%0d got v/t/px/py=%0b/%0d/%0d/%0d want=%0b/%0d/%0d/%0d",
                 $time, hcount, vcount, mon_a.val, mon_a.tsel, mon_a.px, mon_a.py,
                 mon_e.val, mon_e.tsel, mon_e.px, mon_e.py);
      end
    end
    if (map_rd === 1'b1) begin
      checks++;
      if (addr_q.size() == 0) begin
        errors++;
        $display("FAIL spurious_map_rd t=%0t got addr=%0d want no read", $time, map_addr);
      end else begin
        mon_addr = addr_q.pop_front();
        if (map_addr !== 13'(mon_addr)) begin
          errors++;
          $display("FAIL map_addr t=%0t got=%0d want=%0d", $time, map_addr, mon_addr);
        end
      end
    end
  end

  // One pixel clock of stimulus plus the model's expectation for it.
  task automatic step(input int h, input int v, input bit b, input bit clr);
    exp_t e;
    int   vd, x, r;
    bit   busy, trig;
    @(negedge clk);
    hcount  = 10'(h);
    vcount  = 10'(v);
    bright  = b;
    err_clr = clr;
    cyc++;
    if (pend && cyc > swap_cyc) begin
      front_row = pend_row;
      front_rv  = 1'b1;
      pend      = 1'b0;
    end
    busy = pend && (cyc > trig_cyc);
    vd   = (v - 31) & 1023;
    trig = (h == 785) && (vd % 8 == 0) && (vd / 8 < NROWS);
    if (busy && (b || trig)) und_m = 1'b1;
    else if (clr)            und_m = 1'b0;
    if (trig && !busy) begin
      r        = vd / 8;
      pend     = 1'b1;
      trig_cyc = cyc;
      swap_cyc = cyc + NCOLS + 1;
      for (int c = 0; c < NCOLS; c++) begin
        pend_row[c] = map_mem[r * NCOLS + c];
        addr_q.push_back(r * NCOLS + c);
      end
    end
    e     = '0;
    e.und = und_m;
    if (b) begin
      x      = (h - 145) & 1023;
      e.val  = 1'b1;
      e.px   = 3'(x % 8);
      e.py   = 3'(((v - 32) & 1023) % 8);
      e.tsel = front_rv ? front_row[x / 8] : 4'd0;
    end
    exp_q.push_back(e);
  endtask

  task automatic line(input int v);
    for (int h = 0; h < 800; h++)
      step(h, v, (h >= 145 && h <= 784 && v >= 32 && v <= 511), 1'b0);
  endtask

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("reset_map_rd_async", int'(map_rd), 0);
    addr_q.delete();
    pend     = 1'b0;
    front_rv = 1'b0;
    und_m    = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; hcount = '0; vcount = '0; bright = 1'b0; err_clr = 1'b0;
    for (int i = 0; i < NMAP; i++) map_mem[i] = 4'((i % NCOLS) % 16);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_map_rd", int'(map_rd), 0);
    chk("rst_map_addr", int'(map_addr), 0);
    chk("rst_tselect", int'(tselect), 0);
    chk("rst_tselect_valid", int'(tselect_valid), 0);
    chk("rst_px", int'(px), 0);
    chk("rst_py", int'(py), 0);
    chk("rst_underrun", int'(underrun), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Blanking noise: no trigger points, nothing should be read or shown.
    repeat (30) step($urandom_range(0, 784), $urandom_range(0, 524), 1'b0, 1'b0);

    // Frame start, row 0 then row boundary into row 1.
    line(30);
    for (int v = 31; v <= 41; v++) line(v);

    // Underrun: bright during a fetch, a second trigger while busy with a clear.
    step(785, 103, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(145 + i, 104, 1'b1, 1'b0);
    step(785, 103, 1'b0, 1'b1);
    for (int i = 0; i < 80; i++) step(200 + i, 104, 1'b0, 1'b0);
    step(300, 104, 1'b0, 1'b0);
    step(301, 104, 1'b0, 1'b1);
    step(302, 104, 1'b0, 1'b0);
    line(104);

    // Reset during fetch cycle 40: row content must stay hidden until refetched.
    step(785, 111, 1'b0, 1'b0);
    for (int i = 0; i < 39; i++) step(786 + i % 14, 111, 1'b0, 1'b0);
    do_reset();
    line(112);
    line(119);
    line(120);

    // Last row and the suppressed row past the frame.
    line(503);
    line(504);
    line(510);
    line(511);
    line(512);

    // Random map contents and random rows.
    for (int i = 0; i < NMAP; i++) map_mem[i] = 4'($urandom);
    repeat (5) begin
      int r;
      r = $urandom_range(0, NROWS - 1);
      line(31 + 8 * r);
      line(32 + 8 * r + $urandom_range(0, 6));
    end

    @(posedge clk);
    #2;
    chk("exp_queue_drained", exp_q.size(), 0);
    chk("addr_queue_drained", addr_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
